// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch outstanding, hands instructions to the core.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ysyx_24100005_ifu #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        req_valid,
   output logic [31:0] req_addr,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   input  logic        resp_err,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        inst_ready,
`ifdef IFU_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] pc_r;
   logic [31:0] pc_s;
   logic        stale_r;
   logic        stale_s;
   logic [31:0] inst_r;
   logic [31:0] inst_s;
   logic [31:0] inst_pc_r;
   logic [31:0] inst_pc_s;
   logic        inst_fault_r;
   logic        inst_fault_s;
   logic        inst_valid_r;
   logic        pc_aligned_s;
   logic        handshake_s;

   assign pc_aligned_s = (pc_r[1:0] == 2'b00);

   // The reset term keeps the request quiet while reset is held, since state and pc already sit at their reset values.
   assign req_valid   = rst && (state_r == S_REQ) && pc_aligned_s;
   assign req_addr    = pc_r;
   assign handshake_s = req_valid && req_ready;

   assign inst_valid = inst_valid_r;
   assign inst       = inst_r;
   assign inst_pc    = inst_pc_r;
   assign inst_fault = inst_fault_r;

   // Next-state, next-pc and instruction capture; redirect wins over every other event.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      stale_s      = stale_r;
      inst_s       = inst_r;
      inst_pc_s    = inst_pc_r;
      inst_fault_s = inst_fault_r;
      case (state_r)
         S_REQ: begin
            if (redirect_valid) begin
               pc_s = redirect_pc;
               if (handshake_s) begin
                  stale_s = 1'b1;
                  state_s = S_WAIT;
               end else begin
                  state_s = S_REQ;
               end
            end else if (!pc_aligned_s) begin
               inst_s       = FAULT_INST;
               inst_fault_s = 1'b1;
               inst_pc_s    = pc_r;
               state_s      = S_OUT;
            end else if (handshake_s) begin
               state_s = S_WAIT;
            end else begin
               state_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_s = redirect_pc;
            end else begin
               pc_s = pc_r;
            end
            if (resp_valid) begin
               if (stale_r || redirect_valid) begin
                  stale_s = 1'b0;
                  state_s = S_REQ;
               end else begin
                  inst_s       = resp_err ? FAULT_INST : resp_data;
                  inst_fault_s = resp_err;
                  inst_pc_s    = pc_r;
                  state_s      = S_OUT;
               end
            end else if (redirect_valid) begin
               stale_s = 1'b1;
            end else begin
               stale_s = stale_r;
            end
         end
         S_OUT: begin
            if (redirect_valid) begin
               pc_s    = redirect_pc;
               state_s = S_REQ;
            end else if (inst_ready) begin
               pc_s    = pc_r + 32'd4;
               state_s = S_REQ;
            end else begin
               state_s = S_OUT;
            end
         end
         default: begin
            state_s = S_REQ;
         end
      endcase
   end

   // State, pc and instruction registers; inst_valid is registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= S_REQ;
         pc_r         <= RESET_PC;
         stale_r      <= 1'b0;
         inst_r       <= 32'h0000_0000;
         inst_pc_r    <= 32'h0000_0000;
         inst_fault_r <= 1'b0;
         inst_valid_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         stale_r      <= stale_s;
         inst_r       <= inst_s;
         inst_pc_r    <= inst_pc_s;
         inst_fault_r <= inst_fault_s;
         inst_valid_r <= (state_s == S_OUT);
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_r;
   logic [31:0] perf_stall_r;
   logic        fetch_inc_s;
   logic        stall_inc_s;

   assign fetch_inc_s = inst_valid_r && inst_ready && !redirect_valid;
   assign stall_inc_s = (state_r == S_WAIT) || ((state_r == S_REQ) && !req_ready);

   // Free-running wrap-around event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_r <= 32'h0000_0000;
         perf_stall_r <= 32'h0000_0000;
      end else begin
         if (fetch_inc_s) begin
            perf_fetch_r <= perf_fetch_r + 32'd1;
         end else begin
            perf_fetch_r <= perf_fetch_r;
         end
         if (stall_inc_s) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end else begin
            perf_stall_r <= perf_stall_r;
         end
      end
   end

   assign perf_fetch_cnt = perf_fetch_r;
   assign perf_stall_cnt = perf_stall_r;
`endif

endmodule
